// File: rtl/redraw_scheduler.sv
// redraw_scheduler: owns the single framebuffer write port and interleaves a
// full-screen background redraw (on game-state changes) with sprite
// erase/draw passes (on sprite moves). Every output is registered. Outputs are
// decoded from the next state and next counters, so they line up with the
// state they describe.
module redraw_scheduler #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] gameState,
  input  logic       spriteReq,
  input  logic [8:0] spriteX,
  input  logic [7:0] spriteY,
  output logic       plot,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       srcSel,
  output logic [3:0] offX,
  output logic [3:0] offY,
  output logic       busy,
  output logic       doneRedraw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BG,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [8:0] BG_LAST_COL  = 9'(SCREEN_W - 1);
  localparam logic [7:0] BG_LAST_ROW  = 8'(SCREEN_H - 1);
  localparam logic [8:0] BOX_LAST_COL = 9'(SPRITE_W - 1);
  localparam logic [7:0] BOX_LAST_ROW = 8'(SPRITE_H - 1);
  localparam logic [9:0] X_LIMIT      = 10'(SCREEN_W);
  localparam logic [9:0] Y_LIMIT      = 10'(SCREEN_H);

  state_t     state_q, state_d;
  // Shared scan counters: full-screen raster in BG, box offset otherwise.
  logic [8:0] col_q, col_d;
  logic [7:0] row_q, row_d;

  logic [3:0] prev_state_q;
  logic       gs_change;
  logic       bg_pend_q, bg_pend_d;
  logic       spr_pend_q, spr_pend_d;
  // Remembers whether the running pass began with a background redraw.
  logic       from_bg_q, from_bg_d;

  logic [8:0] cur_x_q;
  logic [7:0] cur_y_q;
  // Position of the box currently on screen; also the DRAW base once entered.
  logic [8:0] old_x_q, old_x_d;
  logic [7:0] old_y_q, old_y_d;

  logic [9:0] box_x, box_y;

  logic       plot_q, plot_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       src_q, src_d;
  logic [3:0] offx_q, offx_d;
  logic [3:0] offy_q, offy_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  assign gs_change = (gameState != prev_state_q);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and scan counter advance; a game-state change restarts BG.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (bg_pend_q)       state_d = S_BG;
        else if (spr_pend_q) state_d = S_ERASE;
      end
      S_BG: begin
        if (gs_change) begin
          col_d = '0;
          row_d = '0;
        end else if (col_q == BG_LAST_COL) begin
          col_d = '0;
          if (row_q == BG_LAST_ROW) begin
            row_d   = '0;
            state_d = S_DRAW;
          end else begin
            row_d = row_q + 8'd1;
          end
        end else begin
          col_d = col_q + 9'd1;
        end
      end
      S_ERASE, S_DRAW: begin
        if (col_q == BOX_LAST_COL) begin
          col_d = '0;
          if (row_q == BOX_LAST_ROW) begin
            row_d   = '0;
            state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
          end else begin
            row_d = row_q + 8'd1;
          end
        end else begin
          col_d = col_q + 9'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event bookkeeping: new events win over the clear that consumes them.
  always_comb begin
    // Any cycle that lands in BG (entry or restart) absorbs the change.
    bg_pend_d = bg_pend_q | gs_change;
    if (state_d == S_BG) bg_pend_d = 1'b0;

    spr_pend_d = spr_pend_q;
    if ((state_q == S_IDLE && state_d == S_ERASE) ||
        (state_q == S_BG && state_d == S_DRAW))
      spr_pend_d = 1'b0;
    if (spriteReq) spr_pend_d = 1'b1;

    from_bg_d = from_bg_q;
    if (state_q == S_IDLE && state_d == S_BG)    from_bg_d = 1'b1;
    if (state_q == S_IDLE && state_d == S_ERASE) from_bg_d = 1'b0;

    // Freeze the draw position at DRAW entry so late requests cannot move it.
    old_x_d = old_x_q;
    old_y_d = old_y_q;
    if (state_d == S_DRAW && state_q != S_DRAW) begin
      old_x_d = cur_x_q;
      old_y_d = cur_y_q;
    end
  end

  // Output decode for the coming cycle; box math at 10 bits so wrap cannot unclip.
  always_comb begin
    box_x  = {1'b0, old_x_d} + {1'b0, col_d};
    box_y  = {2'b0, old_y_d} + {2'b0, row_d};
    plot_d = 1'b0;
    x_d    = '0;
    y_d    = '0;
    src_d  = 1'b0;
    offx_d = '0;
    offy_d = '0;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    case (state_d)
      S_BG: begin
        plot_d = 1'b1;
        x_d    = col_d;
        y_d    = row_d;
      end
      S_ERASE, S_DRAW: begin
        plot_d = (box_x < X_LIMIT) && (box_y < Y_LIMIT);
        x_d    = box_x[8:0];
        y_d    = box_y[7:0];
        if (state_d == S_DRAW) begin
          src_d  = 1'b1;
          offx_d = col_d[3:0];
          offy_d = row_d[3:0];
        end
      end
      S_DONE:  done_d = from_bg_q;
      default: ;
    endcase
  end

  // Counters, pending flags and sprite positions.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_state_q <= gameState;
      bg_pend_q    <= 1'b1;
      spr_pend_q   <= 1'b0;
      from_bg_q    <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      prev_state_q <= gameState;
      bg_pend_q    <= bg_pend_d;
      spr_pend_q   <= spr_pend_d;
      from_bg_q    <= from_bg_d;
      if (spriteReq) begin
        cur_x_q <= spriteX;
        cur_y_q <= spriteY;
      end
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
    end
  end

  // Registered framebuffer-port outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      src_q  <= 1'b0;
      offx_q <= '0;
      offy_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      plot_q <= plot_d;
      x_q    <= x_d;
      y_q    <= y_d;
      src_q  <= src_d;
      offx_q <= offx_d;
      offy_q <= offy_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign plot       = plot_q;
  assign x          = x_q;
  assign y          = y_q;
  assign srcSel     = src_q;
  assign offX       = offx_q;
  assign offY       = offy_q;
  assign busy       = busy_q;
  assign doneRedraw = done_q;

endmodule

// File: tb/tb_redraw_scheduler.sv
// Bench for redraw_scheduler. The screen is shrunk to 64x48 so every scenario
// fits a short run; all expectations are derived from the same parameters.
module tb_redraw_scheduler;

  localparam int SCR_W   = 64;
  localparam int SCR_H   = 48;
  localparam int SPR_W   = 16;
  localparam int SPR_H   = 16;
  localparam int BOX     = SPR_W * SPR_H;
  localparam int BG_PIX  = SCR_W * SCR_H;
  localparam int BG_LEN  = BG_PIX + BOX + 1;
  localparam int SPR_LEN = 2 * BOX + 1;

  logic       clock;
  logic       resetn;
  logic [3:0] gameState;
  logic       spriteReq;
  logic [8:0] spriteX;
  logic [7:0] spriteY;
  logic       plot;
  logic [8:0] x;
  logic [7:0] y;
  logic       srcSel;
  logic [3:0] offX;
  logic [3:0] offY;
  logic       busy;
  logic       doneRedraw;

  int checks;
  int failures;

  // Reference model: position on screen (old) and latest requested (cur).
  int m_old_x, m_old_y, m_cur_x, m_cur_y;
  // Sprite pulses to inject during a pass: cycle index within the pass, X, Y.
  int pulse_at[$];
  int pulse_x[$];
  int pulse_y[$];

  redraw_scheduler #(
    .SCREEN_W(SCR_W),
    .SCREEN_H(SCR_H),
    .SPRITE_W(SPR_W),
    .SPRITE_H(SPR_H)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .gameState (gameState),
    .spriteReq (spriteReq),
    .spriteX   (spriteX),
    .spriteY   (spriteY),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .srcSel    (srcSel),
    .offX      (offX),
    .offY      (offY),
    .busy      (busy),
    .doneRedraw(doneRedraw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected port values for cycle i of a pass (BG pass or sprite pass).
  function automatic void model_pixel(input bit is_bg, input int i,
                                      output bit p, output int ex, output int ey,
                                      output bit s, output int ox, output int oy,
                                      output bit d, output bit cxy, output bit coff);
    int k, bx, by;
    p = 0; ex = 0; ey = 0; s = 0; ox = 0; oy = 0; d = 0; cxy = 1; coff = 0;
    if (is_bg && i < BG_PIX) begin
      p  = 1;
      ex = i % SCR_W;
      ey = i / SCR_W;
    end else if (!is_bg && i < BOX) begin
      bx = m_old_x + i % SPR_W;
      by = m_old_y + i / SPR_W;
      p  = (bx < SCR_W) && (by < SCR_H);
      ex = bx % 512;
      ey = by % 256;
    end else begin
      k = is_bg ? i - BG_PIX : i - BOX;
      if (k < BOX) begin
        bx   = m_cur_x + k % SPR_W;
        by   = m_cur_y + k / SPR_W;
        p    = (bx < SCR_W) && (by < SCR_H);
        ex   = bx % 512;
        ey   = by % 256;
        s    = 1;
        ox   = k % SPR_W;
        oy   = k / SPR_W;
        coff = 1;
      end else begin
        cxy = 0;
        d   = is_bg;
      end
    end
  endfunction

  // Follow one pass cycle by cycle against the model; optionally change
  // gameState after BG pixel change_at to force a restart.
  task automatic run_pass(input bit is_bg, input int change_at, input string name,
                          output int plots);
    int i, n, bad, dones, waitc, exp_len;
    bit restarted, p, s, d, cxy, coff;
    int ex, ey, ox, oy;
    string first;
    plots = 0; bad = 0; dones = 0; n = 0; i = 0; waitc = 0; restarted = 0;
    first = "";
    while (busy !== 1'b1 && waitc < 8) begin
      @(negedge clock);
      waitc++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_start busy=%b required=1 within 8 cycles", name, busy);
      return;
    end
    exp_len = is_bg ? BG_LEN : SPR_LEN;
    while (busy === 1'b1 && n < exp_len + change_at + 16) begin
      model_pixel(is_bg, i, p, ex, ey, s, ox, oy, d, cxy, coff);
      if (plot !== p || srcSel !== s || doneRedraw !== d ||
          (cxy && (x !== 9'(ex) || y !== 8'(ey))) ||
          (coff && (offX !== 4'(ox) || offY !== 4'(oy)))) begin
        if (bad == 0)
          first = $sformatf("pass cycle %0d got plot=%b x=%0d y=%0d src=%b off=%0d,%0d done=%b required plot=%b x=%0d y=%0d src=%b off=%0d,%0d done=%b",
                            n, plot, x, y, srcSel, offX, offY, doneRedraw,
                            p, ex, ey, s, ox, oy, d);
        bad++;
      end
      if (plot === 1'b1) plots++;
      if (doneRedraw === 1'b1) dones++;
      spriteReq = 1'b0;
      if (pulse_at.size() > 0 && pulse_at[0] == n) begin
        spriteReq = 1'b1;
        spriteX   = 9'(pulse_x[0]);
        spriteY   = 8'(pulse_y[0]);
        m_cur_x   = pulse_x[0];
        m_cur_y   = pulse_y[0];
        void'(pulse_at.pop_front());
        void'(pulse_x.pop_front());
        void'(pulse_y.pop_front());
      end
      if (!restarted && i == change_at) begin
        gameState = gameState + 4'd1;
        restarted = 1;
        i = 0;
      end else begin
        i++;
      end
      n++;
      @(negedge clock);
    end
    spriteReq = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_pixels %0d bad cycles, first: %s", name, bad, first);
    end
    checks++;
    if (n != exp_len + (restarted ? change_at + 1 : 0)) begin
      failures++;
      $display("FAIL %s_length busy cycles=%0d required=%0d", name, n,
               exp_len + (restarted ? change_at + 1 : 0));
    end
    checks++;
    if (dones != (is_bg ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_done pulses=%0d required=%0d", name, dones, is_bg ? 1 : 0);
    end
    m_old_x = m_cur_x;
    m_old_y = m_cur_y;
  endtask

  // Nothing may start after a pass when no event is outstanding.
  task automatic check_quiet(input string name, input int ncyc);
    int bad;
    bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (busy !== 1'b0 || plot !== 1'b0 || doneRedraw !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_quiet active in %0d of %0d idle cycles, required 0", name, bad, ncyc);
    end
  endtask

  task automatic req_sprite(input int px, input int py);
    spriteReq = 1'b1;
    spriteX   = 9'(px);
    spriteY   = 8'(py);
    m_cur_x   = px;
    m_cur_y   = py;
    @(negedge clock);
    spriteReq = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (plot !== 1'b0) begin
      failures++;
      $display("FAIL %s_plot got=%b required=0", name, plot);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy got=%b required=0", name, busy);
    end
    checks++;
    if (doneRedraw !== 1'b0) begin
      failures++;
      $display("FAIL %s_done got=%b required=0", name, doneRedraw);
    end
    checks++;
    if (x !== 9'd0 || y !== 8'd0 || srcSel !== 1'b0 || offX !== 4'd0 || offY !== 4'd0) begin
      failures++;
      $display("FAIL %s_coords got x=%0d y=%0d src=%b off=%0d,%0d required all 0",
               name, x, y, srcSel, offX, offY);
    end
  endtask

  task automatic test_reset();
    int plots;
    resetn    = 1'b0;
    gameState = 4'd3;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn  = 1'b1;
    m_old_x = 0; m_old_y = 0; m_cur_x = 0; m_cur_y = 0;
    run_pass(1, -1, "reset_bg", plots);
    check_quiet("reset_bg", 6);
  endtask

  task automatic test_sprite_move();
    int plots;
    req_sprite(20, 12);
    run_pass(0, -1, "sprite", plots);
    checks++;
    if (plots != 2 * BOX) begin
      failures++;
      $display("FAIL sprite_plots got=%0d required=%0d", plots, 2 * BOX);
    end
    check_quiet("sprite", 6);
  endtask

  task automatic test_bg_restart();
    int plots;
    gameState = gameState + 4'd1;
    run_pass(1, 1000, "restart", plots);
    check_quiet("restart", 6);
  endtask

  task automatic test_collapse();
    int plots;
    pulse_at = '{100, 500, 900};
    pulse_x  = '{10, 20, 30};
    pulse_y  = '{10, 20, 30};
    gameState = gameState + 4'd1;
    run_pass(1, -1, "collapse", plots);
    check_quiet("collapse", 6);
  endtask

  task automatic test_clip();
    int plots;
    req_sprite(SCR_W - 10, SCR_H - 10);
    run_pass(0, -1, "clip_edge", plots);
    checks++;
    if (plots != BOX + 100) begin
      failures++;
      $display("FAIL clip_edge_plots got=%0d required=%0d", plots, BOX + 100);
    end
    req_sprite(500, 250);
    run_pass(0, -1, "clip_far", plots);
    checks++;
    if (plots != 100) begin
      failures++;
      $display("FAIL clip_far_plots got=%0d required=100", plots);
    end
    check_quiet("clip", 6);
  endtask

  task automatic test_same_cycle();
    int plots;
    gameState = gameState + 4'd1;
    req_sprite(5, 7);
    run_pass(1, -1, "same_cycle", plots);
    check_quiet("same_cycle", 8);
  endtask

  task automatic test_random_moves();
    int plots;
    for (int r = 0; r < 6; r++) begin
      req_sprite(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
      run_pass(0, -1, $sformatf("random%0d", r), plots);
      check_quiet($sformatf("random%0d", r), 3);
    end
  endtask

  task automatic test_reset_mid_erase();
    int plots, waitc;
    req_sprite(40, 20);
    waitc = 0;
    while (busy !== 1'b1 && waitc < 8) begin
      @(negedge clock);
      waitc++;
    end
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    @(negedge clock);
    resetn  = 1'b1;
    m_old_x = 0; m_old_y = 0; m_cur_x = 0; m_cur_y = 0;
    run_pass(1, -1, "mid_reset_bg", plots);
    check_quiet("mid_reset_bg", 6);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    gameState = 4'd0;
    spriteReq = 1'b0;
    spriteX   = '0;
    spriteY   = '0;
    @(negedge clock);
    test_reset();
    test_sprite_move();
    test_bg_restart();
    test_collapse();
    test_clip();
    test_same_cycle();
    test_random_moves();
    test_reset_mid_erase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
